// File: rtl/wave_sequencer_pkg.sv
// Shared types and constants for the waveform schedule sequencer.
package wave_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_AMP   = 2'd1,
      ST_PHASE = 2'd2,
      ST_RUN   = 2'd3
   } seq_state_t;

   // Byte offsets of the fields inside one 4-byte schedule entry
   localparam int unsigned OFF_WAVE        = 0;
   localparam int unsigned OFF_AMP         = 1;
   localparam int unsigned OFF_PHASE       = 2;
   localparam int unsigned OFF_DWELL       = 3;
   localparam int unsigned BYTES_PER_ENTRY = 4;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned DWELL_W = 8;

   // One decoded schedule entry as seen on the table read port
   typedef struct packed {
      logic [1:0]         waveform;
      logic [DATA_W-1:0]  amplitude;
      logic [DATA_W-1:0]  phase;
      logic [DWELL_W-1:0] dwell;
   } entry_t;

endpackage

// File: rtl/wave_sequencer_table.sv
// Byte-addressed schedule table with wrapping write pointer and entry count.
module wave_sequencer_table
   import wave_sequencer_pkg::*;
#(
   parameter int unsigned ENTRIES = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [DATA_W-1:0]           cfg_data_i,
   input  logic                        cfg_valid_strobe_i,
   input  logic                        cfg_clear_i,
   input  logic                        lock_i,
   input  logic [$clog2(ENTRIES)-1:0]  rd_idx_i,
   output entry_t                      rd_entry_o,
   output logic [$clog2(ENTRIES):0]    num_entries_o
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned PTR_W = $clog2(BYTES_PER_ENTRY * ENTRIES);
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [DATA_W-1:0] mem [BYTES_PER_ENTRY * ENTRIES];
   logic [PTR_W-1:0]  wr_ptr;
   logic              wr_en_c;

   // Writes are ignored while the sequencer is playing; clear beats a write
   assign wr_en_c = !lock_i && !cfg_clear_i && cfg_valid_strobe_i;

   // Write pointer and saturating entry count
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr        <= '0;
         num_entries_o <= '0;
      end else if (!lock_i && cfg_clear_i) begin
         wr_ptr        <= '0;
         num_entries_o <= '0;
      end else if (wr_en_c) begin
         wr_ptr <= wr_ptr + PTR_W'(1);
         if (wr_ptr[1:0] == 2'(OFF_DWELL) && num_entries_o != CNT_W'(ENTRIES)) begin
            num_entries_o <= num_entries_o + CNT_W'(1);
         end
      end
   end

   // Table storage; contents are don't-care after reset
   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_en_c) begin
         mem[wr_ptr] <= cfg_data_i;
      end
   end

   // Read port by entry index
   assign rd_entry_o.waveform  = 2'(mem[{rd_idx_i, 2'(OFF_WAVE)}]);
   assign rd_entry_o.amplitude = mem[{rd_idx_i, 2'(OFF_AMP)}];
   assign rd_entry_o.phase     = mem[{rd_idx_i, 2'(OFF_PHASE)}];
   assign rd_entry_o.dwell     = mem[{rd_idx_i, 2'(OFF_DWELL)}];

endmodule

// File: rtl/wave_sequencer.sv
// Plays a programmed schedule into wave_generator: amplitude, phase, then dwell.
module wave_sequencer
   import wave_sequencer_pkg::*;
#(
   parameter int unsigned ENTRIES = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [7:0]                  cfg_data_i,
   input  logic                        cfg_valid_strobe_i,
   input  logic                        cfg_clear_i,
   input  logic                        run_i,
   input  logic                        loop_i,
   input  logic                        sample_strobe_i,
   output logic                        enable_o,
   output logic [1:0]                  waveform_o,
   output logic                        set_amplitude_strobe_o,
   output logic                        set_phase_strobe_o,
   output logic [7:0]                  data_o,
   output logic [$clog2(ENTRIES)-1:0]  entry_o,
   output logic                        busy_o,
   output logic                        done_strobe_o
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned CNT_W = IDX_W + 1;

   seq_state_t         state;
   entry_t             rd_entry;
   logic [CNT_W-1:0]   num_entries;
   logic [IDX_W-1:0]   rd_idx;
   logic [DWELL_W-1:0] sample_cnt;
   logic [DWELL_W-1:0] dwell_r;
   logic               last_entry_c;

   wave_sequencer_table #(.ENTRIES(ENTRIES)) u_table (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .cfg_data_i         (cfg_data_i),
      .cfg_valid_strobe_i (cfg_valid_strobe_i),
      .cfg_clear_i        (cfg_clear_i),
      .lock_i             (busy_o),
      .rd_idx_i           (rd_idx),
      .rd_entry_o         (rd_entry),
      .num_entries_o      (num_entries)
   );

   assign last_entry_c = (CNT_W'(entry_o) + CNT_W'(1)) >= num_entries;

   // Read index: the entry the next AMP will load (IDLE/RUN), else the active one
   always_comb begin
      rd_idx = entry_o;
      case (state)
         ST_IDLE: rd_idx = '0;
         ST_RUN:  rd_idx = last_entry_c ? '0 : entry_o + IDX_W'(1);
         default: rd_idx = entry_o;
      endcase
   end

   // Sequencer FSM, sample counter and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state                  <= ST_IDLE;
         entry_o                <= '0;
         sample_cnt             <= '0;
         dwell_r                <= '0;
         enable_o               <= 1'b0;
         waveform_o             <= '0;
         set_amplitude_strobe_o <= 1'b0;
         set_phase_strobe_o     <= 1'b0;
         data_o                 <= '0;
         busy_o                 <= 1'b0;
         done_strobe_o          <= 1'b0;
      end else begin
         set_amplitude_strobe_o <= 1'b0;
         set_phase_strobe_o     <= 1'b0;
         data_o                 <= '0;
         done_strobe_o          <= 1'b0;
         if (state != ST_IDLE && !run_i) begin
            state      <= ST_IDLE;
            enable_o   <= 1'b0;
            waveform_o <= '0;
            busy_o     <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (run_i && num_entries != '0) begin
                     state                  <= ST_AMP;
                     entry_o                <= '0;
                     busy_o                 <= 1'b1;
                     waveform_o             <= rd_entry.waveform;
                     set_amplitude_strobe_o <= 1'b1;
                     data_o                 <= rd_entry.amplitude;
                  end
               end
               ST_AMP: begin
                  state              <= ST_PHASE;
                  set_phase_strobe_o <= 1'b1;
                  data_o             <= rd_entry.phase;
               end
               ST_PHASE: begin
                  state      <= ST_RUN;
                  sample_cnt <= '0;
                  dwell_r    <= rd_entry.dwell;
                  enable_o   <= 1'b1;
               end
               ST_RUN: begin
                  if (sample_strobe_i) begin
                     // dwell 0 wraps to 255 here, giving 256 samples
                     if (sample_cnt == dwell_r - DWELL_W'(1)) begin
                        if (!last_entry_c || loop_i) begin
                           state                  <= ST_AMP;
                           entry_o                <= rd_idx;
                           enable_o               <= 1'b0;
                           waveform_o             <= rd_entry.waveform;
                           set_amplitude_strobe_o <= 1'b1;
                           data_o                 <= rd_entry.amplitude;
                        end else begin
                           state         <= ST_IDLE;
                           enable_o      <= 1'b0;
                           waveform_o    <= '0;
                           busy_o        <= 1'b0;
                           done_strobe_o <= 1'b1;
                        end
                     end else begin
                        sample_cnt <= sample_cnt + DWELL_W'(1);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: schedule-level model plus directed literals.
module tb_wave_sequencer;

   localparam int ENT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cfg_data = '0;
   logic       cfg_valid = 1'b0;
   logic       cfg_clear = 1'b0;
   logic       run = 1'b0;
   logic       loop = 1'b0;
   logic       sample = 1'b0;

   logic       enable_o;
   logic [1:0] waveform_o;
   logic       set_amplitude_strobe_o;
   logic       set_phase_strobe_o;
   logic [7:0] data_o;
   logic [1:0] entry_o;
   logic       busy_o;
   logic       done_strobe_o;

   always #5 clk = ~clk;

   wave_sequencer #(.ENTRIES(ENT)) dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .cfg_data_i             (cfg_data),
      .cfg_valid_strobe_i     (cfg_valid),
      .cfg_clear_i            (cfg_clear),
      .run_i                  (run),
      .loop_i                 (loop),
      .sample_strobe_i        (sample),
      .enable_o               (enable_o),
      .waveform_o             (waveform_o),
      .set_amplitude_strobe_o (set_amplitude_strobe_o),
      .set_phase_strobe_o     (set_phase_strobe_o),
      .data_o                 (data_o),
      .entry_o                (entry_o),
      .busy_o                 (busy_o),
      .done_strobe_o          (done_strobe_o)
   );

   int passes = 0;
   int checks = 0;
   int fails  = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- schedule-level reference model ----------------
   logic [7:0] tab [4*ENT];
   int m_ptr = 0, m_cnt = 0, m_entry = 0, m_step = 0, m_samples = 0;
   bit m_active = 0, m_done = 0, was_active = 0;

   function automatic int dwell_of(input int e);
      int d;
      d = int'(tab[4*e+3]);
      return (d == 0) ? 256 : d;
   endfunction

   // m_step: 0 = loading amplitude, 1 = loading phase, 2 = playing samples
   always @(posedge clk) begin
      was_active = m_active;
      m_done = 0;
      if (rst) begin
         m_ptr = 0; m_cnt = 0; m_active = 0; m_entry = 0; m_step = 0; m_samples = 0;
      end else begin
         if (m_active) begin
            if (!run) m_active = 0;
            else if (m_step < 2) begin
               m_step++;
               m_samples = 0;
            end else if (sample) begin
               m_samples++;
               if (m_samples == dwell_of(m_entry)) begin
                  if (m_entry + 1 < m_cnt) begin m_entry++; m_step = 0; end
                  else if (loop) begin m_entry = 0; m_step = 0; end
                  else begin m_active = 0; m_done = 1; end
               end
            end
         end else if (run && m_cnt > 0) begin
            m_active = 1; m_entry = 0; m_step = 0;
         end
         if (!was_active) begin
            if (cfg_clear) begin m_ptr = 0; m_cnt = 0; end
            else if (cfg_valid) begin
               tab[m_ptr] = cfg_data;
               if (m_ptr % 4 == 3 && m_cnt < ENT) m_cnt++;
               m_ptr = (m_ptr + 1) % (4*ENT);
            end
         end
      end
   end

   int e_data, e_wave;
   // Compare every output against the model each cycle
   always @(negedge clk) begin
      if (chk_en) begin
         e_data = 0;
         if (m_active && m_step == 0) e_data = int'(tab[4*m_entry+1]);
         if (m_active && m_step == 1) e_data = int'(tab[4*m_entry+2]);
         e_wave = m_active ? int'(tab[4*m_entry] & 8'h03) : 0;
         chk("m_busy",     busy_o,                 int'(m_active));
         chk("m_enable",   enable_o,               int'(m_active && m_step == 2));
         chk("m_amp_stb",  set_amplitude_strobe_o, int'(m_active && m_step == 0));
         chk("m_ph_stb",   set_phase_strobe_o,     int'(m_active && m_step == 1));
         chk("m_data",     data_o,                 e_data);
         chk("m_waveform", waveform_o,             e_wave);
         chk("m_entry",    entry_o,                m_entry);
         chk("m_done",     done_strobe_o,          int'(m_done));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1; run = 0; loop = 0; sample = 0; cfg_valid = 0; cfg_clear = 0;
      tick(1);
      rst = 0;
   endtask

   task automatic wr(input logic [7:0] b);
      cfg_data = b; cfg_valid = 1;
      tick(1);
      cfg_valid = 0;
   endtask

   task automatic wr_entry(input int w, input int a, input int p, input int d);
      wr(8'(w)); wr(8'(a)); wr(8'(p)); wr(8'(d));
   endtask

   task automatic wait_enable;
      bit ok;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (enable_o) ok = 1;
         else tick(1);
      end
      chk("wait_enable", ok, 1);
   endtask

   int got_amps [8];
   int got_n;

   // Plays the schedule once with a strobe every cycle, logging amplitudes
   task automatic play_once;
      bit fin;
      fin = 0; got_n = 0;
      loop = 0; sample = 1; run = 1;
      for (int i = 0; i < 2000 && !fin; i++) begin
         tick(1);
         if (set_amplitude_strobe_o && got_n < 8) begin got_amps[got_n] = data_o; got_n++; end
         if (done_strobe_o) fin = 1;
      end
      run = 0; sample = 0;
      chk("play_done", fin, 1);
      tick(1);
   endtask

   int seq [4];
   int ns, gap, n;
   bit prev_en, done_seen;

   initial begin
      do_reset;
      chk_en = 1;
      chk("rst_busy", busy_o, 0);
      chk("rst_enable", enable_o, 0);
      chk("rst_data", data_o, 0);

      // single entry, no loop
      wr_entry(2, 'h80, 'h10, 3);
      run = 1;
      tick(1);
      chk("t1_amp_stb", set_amplitude_strobe_o, 1);
      chk("t1_amp_data", data_o, 'h80);
      tick(1);
      chk("t1_ph_stb", set_phase_strobe_o, 1);
      chk("t1_ph_data", data_o, 'h10);
      tick(1);
      chk("t1_enable", enable_o, 1);
      chk("t1_wave", waveform_o, 2);
      sample = 1;
      tick(2);
      chk("t1_not_done", done_strobe_o, 0);
      tick(1);
      chk("t1_done", done_strobe_o, 1);
      chk("t1_idle", busy_o, 0);
      run = 0; sample = 0;
      tick(1);
      chk("t1_done_once", done_strobe_o, 0);

      // loop over two entries
      do_reset;
      wr_entry(1, 'h20, 'h30, 1);
      wr_entry(3, 'h40, 'h50, 2);
      loop = 1; sample = 1; run = 1;
      ns = 0; gap = 0; prev_en = 0; done_seen = 0;
      for (int i = 0; i < 24; i++) begin
         tick(1);
         if (done_strobe_o) done_seen = 1;
         if (enable_o) begin
            if (!prev_en) begin
               if (ns < 4) seq[ns] = entry_o;
               ns++;
               chk("t2_gap", gap, 2);
            end
            gap = 0;
         end else gap++;
         prev_en = enable_o;
      end
      run = 0; sample = 0; loop = 0;
      tick(1);
      chk("t2_no_done", done_seen, 0);
      chk("t2_enough_entries", int'(ns >= 4), 1);
      for (int i = 0; i < 4; i++) chk("t2_entry_seq", seq[i], i % 2);

      // stop mid-RUN, re-run, and stop racing the final strobe
      do_reset;
      wr_entry(0, 1, 2, 5);
      run = 1;
      wait_enable;
      sample = 1;
      tick(1);
      sample = 0; run = 0;
      tick(1);
      chk("t3_stop_enable", enable_o, 0);
      chk("t3_stop_busy", busy_o, 0);
      chk("t3_stop_done", done_strobe_o, 0);
      run = 1;
      wait_enable;
      chk("t3_rerun_entry", entry_o, 0);
      sample = 1;
      tick(4);
      chk("t3_fresh_count", done_strobe_o, 0);
      tick(1);
      chk("t3_done", done_strobe_o, 1);
      sample = 0; run = 0;
      tick(1);
      run = 1;
      wait_enable;
      sample = 1;
      tick(4);
      run = 0;
      tick(1);
      chk("t3_race_no_done", done_strobe_o, 0);
      chk("t3_race_idle", busy_o, 0);
      sample = 0;

      // dwell byte 0 means 256 samples; run with an empty table stays idle
      do_reset;
      wr_entry(1, 5, 6, 0);
      run = 1;
      wait_enable;
      sample = 1;
      n = 0; done_seen = 0;
      for (int i = 0; i < 400 && !done_seen; i++) begin
         tick(1);
         n++;
         if (done_strobe_o) done_seen = 1;
      end
      chk("t4_dwell0", n, 256);
      run = 0; sample = 0;
      do_reset;
      run = 1;
      tick(3);
      chk("t4_empty_idle", busy_o, 0);
      chk("t4_empty_amp", set_amplitude_strobe_o, 0);
      run = 0;

      // pointer wrap, saturating count, busy writes, clear-vs-write
      do_reset;
      for (int e = 0; e < 5; e++) wr_entry(e % 4, 'h11 * (e + 1), 'h0a + e, 1);
      play_once;
      chk("t5_count", got_n, 4);
      chk("t5_overwrite", got_amps[0], 'h55);
      chk("t5_entry1", got_amps[1], 'h22);
      chk("t5_entry3", got_amps[3], 'h44);
      run = 1;
      wait_enable;
      wr_entry(0, 'hEE, 0, 1);
      run = 0;
      tick(1);
      wr_entry(2, 'h77, 1, 1);
      play_once;
      chk("t5_busy_dropped", got_amps[0], 'h55);
      chk("t5_ptr_kept", got_amps[1], 'h77);
      cfg_clear = 1; cfg_valid = 1; cfg_data = 8'h02;
      tick(1);
      cfg_clear = 0; cfg_valid = 0;
      wr_entry(1, 'h99, 3, 1);
      play_once;
      chk("t5_clear_count", got_n, 1);
      chk("t5_clear_wins", got_amps[0], 'h99);

      // reset during PHASE
      do_reset;
      wr_entry(1, 'h60, 'h70, 2);
      run = 1;
      tick(2);
      chk("t6_in_phase", set_phase_strobe_o, 1);
      rst = 1;
      tick(1);
      chk("t6_ph_stb", set_phase_strobe_o, 0);
      chk("t6_data", data_o, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_enable", enable_o, 0);
      chk("t6_entry", entry_o, 0);
      rst = 0;
      tick(3);
      chk("t6_count_cleared", busy_o, 0);
      run = 0;

      // randomized schedules, strobes, stops and configuration traffic
      for (int it = 0; it < 12; it++) begin
         do_reset;
         n = $urandom_range(1, ENT);
         for (int e = 0; e < n; e++)
            wr_entry($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(1, 6));
         loop = 1'($urandom_range(0, 1));
         run = 1;
         for (int c = 0; c < 150; c++) begin
            sample = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) run = ~run;
            cfg_valid = 0; cfg_clear = 0;
            if (!run || busy_o) begin
               cfg_valid = ($urandom_range(0, 15) == 0);
               cfg_clear = ($urandom_range(0, 60) == 0);
               cfg_data  = 8'($urandom_range(1, 255));
            end
            tick(1);
         end
         run = 0; sample = 0; cfg_valid = 0; cfg_clear = 0;
         tick(2);
      end

      chk_en = 0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
